// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: 16x baud tick generator and 4-byte command packet parser (SYNC, CMD, ARG, CHK) with valid/ready output.
// Define UART_CMD_STATS_EN to add saturating error/overrun counters with a synchronous clear.
module uart_cmd_ctrl #(
  parameter int         CLK_DIV       = 27,
  parameter int         TIMEOUT_TICKS = 512,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5
) (
`ifdef UART_CMD_STATS_EN
  output logic [15:0] o_err_count,
  output logic [15:0] o_ovr_count,
  input  logic        i_stats_clr,
`endif
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_baud_tick,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_rx_frame_err,
  output logic [7:0] o_cmd,
  output logic [7:0] o_arg,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic       o_err_pulse,
  output logic       o_overrun
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  typedef enum logic [2:0] {SYNC, CMD, ARG, CHK, HOLD} state_t;
  state_t state, state_n;
  logic [DW-1:0] div;
  logic [TW-1:0] tcnt;
  logic [7:0] cmd_r, arg_r;
  logic fe_q, fe_rise, err_n, ovr_n, expired, in_pkt;
  assign o_baud_tick = div == DW'(CLK_DIV - 1);
  assign fe_rise = i_rx_frame_err & ~fe_q;
  assign o_cmd_valid = state == HOLD;
  assign in_pkt = state == CMD || state == ARG || state == CHK;
  assign expired = in_pkt && tcnt == TW'(TIMEOUT_TICKS);
  // Priority: HOLD ignores framing errors; elsewhere frame error beats a byte, and a byte beats timeout.
  always_comb begin
    state_n = state;
    err_n = 1'b0;
    ovr_n = 1'b0;
    if (state == HOLD) begin
      ovr_n = i_rx_valid;
      state_n = i_cmd_ready ? SYNC : HOLD;
    end else if (fe_rise) begin
      err_n = 1'b1;
      state_n = SYNC;
    end else if (i_rx_valid) begin
      case (state)
        SYNC: state_n = i_rx_data == SYNC_BYTE ? CMD : SYNC;
        CMD: state_n = ARG;
        ARG: state_n = CHK;
        default: begin
          state_n = i_rx_data == (SYNC_BYTE ^ cmd_r ^ arg_r) ? HOLD : SYNC;
          err_n = state_n == SYNC;
        end
      endcase
    end else if (expired) begin
      err_n = 1'b1;
      state_n = SYNC;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= SYNC;
      div <= '0;
      tcnt <= '0;
      cmd_r <= '0;
      arg_r <= '0;
      o_cmd <= '0;
      o_arg <= '0;
      o_err_pulse <= 1'b0;
      o_overrun <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      state <= state_n;
      div <= o_baud_tick ? '0 : div + DW'(1);
      tcnt <= (!in_pkt || state_n != state || i_rx_valid) ? '0 : tcnt + TW'(o_baud_tick);
      cmd_r <= (state == CMD && state_n == ARG) ? i_rx_data : cmd_r;
      arg_r <= (state == ARG && state_n == CHK) ? i_rx_data : arg_r;
      o_cmd <= (state == CHK && state_n == HOLD) ? cmd_r : o_cmd;
      o_arg <= (state == CHK && state_n == HOLD) ? arg_r : o_arg;
      o_err_pulse <= err_n;
      o_overrun <= ovr_n;
      fe_q <= i_rx_frame_err;
    end
  end
`ifdef UART_CMD_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err_count <= '0;
      o_ovr_count <= '0;
    end else if (i_stats_clr) begin
      o_err_count <= '0;
      o_ovr_count <= '0;
    end else begin
      o_err_count <= (o_err_pulse && o_err_count != 16'hFFFF) ? o_err_count + 16'd1 : o_err_count;
      o_ovr_count <= (o_overrun && o_ovr_count != 16'hFFFF) ? o_ovr_count + 16'd1 : o_ovr_count;
    end
  end
`endif
endmodule
